// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: stochastic-to-binary converter.
// Counts the 1s on a unipolar bitstream over a window of 2^LEN cycles.
// The result is presented with a valid/ready handshake.
// Optional build macro SC_DECODE_BIPOLAR_EN changes the result encoding.
// When it is defined, value is the LEN+2 bit two's complement 2*count - 2^LEN.
// When it is undefined, value is the LEN+1 bit unsigned count.
module sc_stream_decoder #(
  parameter int unsigned LEN = 8,
`ifdef SC_DECODE_BIPOLAR_EN
  localparam int unsigned VW = LEN + 2
`else
  localparam int unsigned VW = LEN + 1
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_stream,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] value
);

  localparam int unsigned CW = LEN + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_n;
  logic [LEN-1:0]  r_win;
  logic [LEN-1:0]  w_win_n;
  logic            r_busy;
  logic            w_busy_n;
  logic            r_valid;
  logic            w_valid_n;
  logic [VW-1:0]   r_value;
  logic [VW-1:0]   w_value_n;
  logic [CW-1:0]   w_final;
  logic [VW-1:0]   w_result;
  logic            w_last;

  // Running count including the bit sampled at this edge.
  assign w_final = r_count + CW'(in_stream);

  // The window counter wraps to zero on the last sample.
  assign w_last  = (r_win == {LEN{1'b1}});

`ifdef SC_DECODE_BIPOLAR_EN
  localparam logic [VW-1:0] BIAS = VW'(2 ** LEN);
  // Bipolar encoding: 2*count - 2^LEN, which lies in -2^LEN .. +2^LEN.
  assign w_result = VW'({w_final, 1'b0}) - BIAS;
`else
  // Unipolar encoding: the count itself.
  assign w_result = VW'(w_final);
`endif

  // Next-state and next-output logic for the IDLE/COUNT/DONE sequence.
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_win_n   = r_win;
    w_busy_n  = r_busy;
    w_valid_n = r_valid;
    w_value_n = r_value;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n = COUNT;
          w_count_n = '0;
          w_win_n   = '0;
          w_busy_n  = 1'b1;
        end
      end
      COUNT: begin
        w_count_n = w_final;
        w_win_n   = r_win + LEN'(1);
        if (w_last) begin
          w_state_n = DONE;
          w_valid_n = 1'b1;
          w_value_n = w_result;
        end
      end
      DONE: begin
        // start is ignored here, even when it arrives together with out_ready.
        if (out_ready) begin
          w_state_n = IDLE;
          w_valid_n = 1'b0;
          w_busy_n  = 1'b0;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
        w_valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset has priority over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_win   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_value <= '0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_win   <= w_win_n;
      r_busy  <= w_busy_n;
      r_valid <= w_valid_n;
      r_value <= w_value_n;
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign value     = r_value;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder with LEN=4, which gives a 16-cycle window.
module tb_sc_stream_decoder;

  localparam int unsigned LEN = 4;
`ifdef SC_DECODE_BIPOLAR_EN
  localparam int unsigned VW = LEN + 2;
`else
  localparam int unsigned VW = LEN + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_stream;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] value;

  int n_checks = 0;
  int n_fail   = 0;

  sc_stream_decoder #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_stream (in_stream),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value     (value)
  );

  always #5 clk = ~clk;

  // Expected decoded value for a window containing c ones.
  function automatic logic [VW-1:0] exp_val(input int c);
`ifdef SC_DECODE_BIPOLAR_EN
    return VW'(2 * c - 16);
`else
    return VW'(c);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept start, then feed 16 samples (pat[0] first).
  // start_at >= 0 re-pulses start at that sample index.
  task automatic do_conv(input string tag, input logic [15:0] pat, input int ones,
                         input int start_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      in_stream = pat[i];
      start     = (i == start_at);
      if (i == 15) check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      tick();
    end
    start     = 1'b0;
    in_stream = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_value"}, 32'(value), 32'(exp_val(ones)));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_hs_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_stream = 1'b0; out_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);

    // The bit present at the accepting edge must not be counted.
    in_stream = 1'b1;
    do_conv("ones", 16'hFFFF, 16, -1);

    // Result held while the consumer stalls.
    for (int k = 0; k < 6; k++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_value", 32'(value), 32'(exp_val(16)));
    end
    handshake("ones");
    check("ones_value_kept", 32'(value), 32'(exp_val(16)));

    // out_ready has no effect in IDLE.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_valid", 32'(out_valid), 32'd0);
    check("idle_ready_busy", 32'(busy), 32'd0);

    do_conv("zeros", 16'h0000, 0, -1);
    handshake("zeros");

    do_conv("alt", 16'h5555, 8, -1);
    handshake("alt");

    // A start in COUNT is ignored. A start in DONE with out_ready is also ignored.
    do_conv("ign", 16'hFFFF, 16, 5);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("ign_hs_busy", 32'(busy), 32'd0);
    check("ign_hs_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check("ign_idle_busy", 32'(busy), 32'd0);

    // Abort mid-count with reset, then run a clean conversion.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_stream = 1'b1;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_value", 32'(value), 32'd0);
    tick();
    check("abort_idle_busy", 32'(busy), 32'd0);
    do_conv("fresh", 16'hFFFF, 16, -1);
    handshake("fresh");

    // Back-to-back conversions: start in the cycle after the handshake.
    do_conv("b2b3", 16'h0007, 3, -1);
    handshake("b2b3");
    do_conv("b2b13", 16'h1FFF, 13, -1);
    handshake("b2b13");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
